// File: rtl/rd53_reset_pkg.sv
// rd53_reset_pkg: shared types and defaults for the RD53 reset sequencer.
//   rstseq_state_t : sequencer FSM states
//   DEF_*          : default cycle counts / domain count
//   cnt_width()    : counter width for a given maximum count (clog2, min 1)
package rd53_reset_pkg;

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    DEBOUNCE = 3'd1,
    RELEASE  = 3'd2,
    RUN      = 3'd3,
    SWHOLD   = 3'd4
  } rstseq_state_t;

  localparam int unsigned DEF_NUM_DOMAINS   = 4;
  localparam int unsigned DEF_DEBOUNCE_CYC  = 64;
  localparam int unsigned DEF_STAGE_GAP_CYC = 16;
  localparam int unsigned DEF_SW_HOLD_CYC   = 32;
  localparam int unsigned DEF_SYNC_STAGES   = 2;

  // Counters only ever reach max_val-1, so clog2(max_val) bits suffice.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val <= 1) return 1;
    return unsigned'($clog2(max_val));
  endfunction

endpackage

// File: rtl/rd53_sync_rst_n.sv
// rd53_sync_rst_n: multi-flop synchronizer for an asynchronous level input.
//   i_clk : destination clock
//   i_rst : asynchronous active-high reset, clears every stage to 0
//   i_d   : asynchronous input
//   o_q   : synchronized output (last stage)
module rd53_sync_rst_n #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/rd53_reset_sequencer.sv
// rd53_reset_sequencer: filters the POR macro output and releases the
// active-low domain resets one at a time (bit 0 first), with a software
// request path that re-runs the whole sequence.
//   i_clk          : system clock
//   i_reset        : asynchronous active-high reset, forces HOLD
//   i_por_b        : asynchronous active-low POR, synchronized internally
//   i_sw_rst_req   : single-cycle request for a full reset sequence
//   o_rst_b_out    : active-low domain resets, registered
//   o_seq_done     : all domains released (FSM in RUN), registered
//   o_seq_busy     : FSM not in RUN, registered
// Optional (macro RSTSEQ_EVENT_CNT_EN):
//   o_por_evt_cnt  : saturating count of POR-caused returns to HOLD
//   o_sw_evt_cnt   : saturating count of accepted software requests
module rd53_reset_sequencer
  import rd53_reset_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS   = DEF_NUM_DOMAINS,
  parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int unsigned STAGE_GAP_CYC = DEF_STAGE_GAP_CYC,
  parameter int unsigned SW_HOLD_CYC   = DEF_SW_HOLD_CYC,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_por_b,
  input  logic                   i_sw_rst_req,
  output logic [NUM_DOMAINS-1:0] o_rst_b_out,
  output logic                   o_seq_done,
  output logic                   o_seq_busy
`ifdef RSTSEQ_EVENT_CNT_EN
  ,
  output logic [7:0]             o_por_evt_cnt,
  output logic [7:0]             o_sw_evt_cnt
`endif
);

  localparam int unsigned MaxAB  = (DEBOUNCE_CYC > STAGE_GAP_CYC) ? DEBOUNCE_CYC : STAGE_GAP_CYC;
  localparam int unsigned MaxCyc = (MaxAB > SW_HOLD_CYC) ? MaxAB : SW_HOLD_CYC;
  localparam int unsigned CntW   = cnt_width(MaxCyc);
  localparam int unsigned StgW   = cnt_width(NUM_DOMAINS);

  localparam logic [CntW-1:0] DebLast   = CntW'(DEBOUNCE_CYC - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(STAGE_GAP_CYC - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(SW_HOLD_CYC - 1);
  localparam logic [StgW-1:0] LastStage = StgW'(NUM_DOMAINS - 1);

  logic                   w_por_s;
  rstseq_state_t          r_state, w_state_d;
  logic [CntW-1:0]        r_cnt, w_cnt_d;
  logic [StgW-1:0]        r_stage, w_stage_d;
  logic [NUM_DOMAINS-1:0] r_rst_b, w_rst_b_d;
  logic                   r_done, r_busy, w_done_d;

  rd53_sync_rst_n #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_por_sync (
    .i_clk(i_clk),
    .i_rst(i_reset),
    .i_d  (i_por_b),
    .o_q  (w_por_s)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= HOLD;
      r_cnt   <= '0;
      r_stage <= '0;
      r_rst_b <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_stage <= w_stage_d;
      r_rst_b <= w_rst_b_d;
      r_done  <= w_done_d;
      r_busy  <= ~w_done_d;
    end
  end

  // Reset outputs are computed one cycle ahead so every output is a flop.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_stage_d = r_stage;
    w_rst_b_d = r_rst_b;
    if (r_state != HOLD && !w_por_s) begin
      w_state_d = HOLD;
      w_cnt_d   = '0;
      w_stage_d = '0;
      w_rst_b_d = '0;
    end else if (r_state != HOLD && i_sw_rst_req) begin
      // Also restarts the hold count when already in SWHOLD.
      w_state_d = SWHOLD;
      w_cnt_d   = '0;
      w_stage_d = '0;
      w_rst_b_d = '0;
    end else begin
      unique case (r_state)
        HOLD: begin
          w_cnt_d   = '0;
          w_stage_d = '0;
          w_rst_b_d = '0;
          if (w_por_s) w_state_d = DEBOUNCE;
        end
        DEBOUNCE: begin
          if (r_cnt == DebLast) begin
            // Bit 0 is released on the same edge that enters RELEASE.
            w_state_d = RELEASE;
            w_cnt_d   = '0;
            w_stage_d = '0;
            w_rst_b_d = NUM_DOMAINS'(1);
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        RELEASE: begin
          if (r_stage == LastStage) begin
            w_state_d = RUN;
            w_cnt_d   = '0;
          end else if (r_cnt == GapLast) begin
            w_cnt_d              = '0;
            w_stage_d            = r_stage + StgW'(1);
            w_rst_b_d[w_stage_d] = 1'b1;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        RUN: begin
        end
        SWHOLD: begin
          if (r_cnt == HoldLast) begin
            w_state_d = DEBOUNCE;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        default: begin
          w_state_d = HOLD;
          w_cnt_d   = '0;
          w_stage_d = '0;
          w_rst_b_d = '0;
        end
      endcase
    end
    w_done_d = (w_state_d == RUN);
  end

  assign o_rst_b_out = r_rst_b;
  assign o_seq_done  = r_done;
  assign o_seq_busy  = r_busy;

`ifdef RSTSEQ_EVENT_CNT_EN
  logic       w_por_evt, w_sw_evt;
  logic [7:0] r_por_evt_cnt, r_sw_evt_cnt;

  // Same priority as the FSM: a POR drop masks a simultaneous request.
  assign w_por_evt = (r_state != HOLD) && !w_por_s;
  assign w_sw_evt  = (r_state != HOLD) && w_por_s && i_sw_rst_req;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_por_evt_cnt <= '0;
      r_sw_evt_cnt  <= '0;
    end else begin
      if (w_por_evt && r_por_evt_cnt != 8'hFF) r_por_evt_cnt <= r_por_evt_cnt + 8'd1;
      if (w_sw_evt && r_sw_evt_cnt != 8'hFF) r_sw_evt_cnt <= r_sw_evt_cnt + 8'd1;
    end
  end

  assign o_por_evt_cnt = r_por_evt_cnt;
  assign o_sw_evt_cnt  = r_sw_evt_cnt;
`endif

endmodule

// File: tb/tb_rd53_reset_sequencer.sv
// tb_rd53_reset_sequencer: directed bench for rd53_reset_sequencer with
// default parameters. Inputs change and outputs are sampled on the falling
// edge; step(n) advances n falling edges, so "step(k) after a change" reads
// the state left by the k-th rising edge after that change.
module tb_rd53_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       por_b;
  logic       sw_req;
  logic [3:0] rst_b;
  logic       done;
  logic       busy;
`ifdef RSTSEQ_EVENT_CNT_EN
  logic [7:0] por_evt;
  logic [7:0] sw_evt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rd53_reset_sequencer dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_por_b     (por_b),
    .i_sw_rst_req(sw_req),
    .o_rst_b_out (rst_b),
    .o_seq_done  (done),
    .o_seq_busy  (busy)
`ifdef RSTSEQ_EVENT_CNT_EN
    ,
    .o_por_evt_cnt(por_evt),
    .o_sw_evt_cnt (sw_evt)
`endif
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    por_b  = 1'b0;
    sw_req = 1'b0;
    step(2);
    chk("reset_rst_b", 32'(rst_b), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    step(2);

    // Power-up: 2 sync + 64 debounce + 1, then 16-cycle stage gaps.
    por_b = 1'b1;
    step(66);  chk("pwr_b0_pending", 32'(rst_b), 32'h0);
    step(1);   chk("pwr_b0", 32'(rst_b), 32'h1);
    chk("pwr_busy", 32'(busy), 32'h1);
    step(15);  chk("pwr_b1_pending", 32'(rst_b), 32'h1);
    step(1);   chk("pwr_b1", 32'(rst_b), 32'h3);
    step(16);  chk("pwr_b2", 32'(rst_b), 32'h7);
    step(16);  chk("pwr_b3", 32'(rst_b), 32'hF);
    chk("pwr_done_lag", 32'(done), 32'h0);
    step(1);   chk("pwr_done", 32'(done), 32'h1);
    chk("pwr_not_busy", 32'(busy), 32'h0);

    // Software request from RUN: 32 hold + 64 debounce, bit0 at edge 97.
    sw_req = 1'b1;
    step(1);
    sw_req = 1'b0;
    chk("sw_rst_b", 32'(rst_b), 32'h0);
    chk("sw_done", 32'(done), 32'h0);
    chk("sw_busy", 32'(busy), 32'h1);
    step(95);  chk("sw_b0_pending", 32'(rst_b), 32'h0);
    chk("sw_busy_held", 32'(busy), 32'h1);
    step(1);   chk("sw_b0", 32'(rst_b), 32'h1);
    step(48);  chk("sw_b3", 32'(rst_b), 32'hF);
    chk("sw_busy_b3", 32'(busy), 32'h1);
    step(1);   chk("sw_done_again", 32'(done), 32'h1);

    // POR drop from RUN: resets fall on the third edge.
    por_b = 1'b0;
    step(2);   chk("por_fall_sync", 32'(rst_b), 32'hF);
    step(1);   chk("por_fall_rst_b", 32'(rst_b), 32'h0);
    chk("por_fall_busy", 32'(busy), 32'h1);

    // Restart with a 1-cycle POR glitch at debounce count 40.
    por_b = 1'b1;
    step(43);
    por_b = 1'b0;
    step(1);
    por_b = 1'b1;
    step(23);  chk("glitch_no_credit", 32'(rst_b), 32'h0);
    step(43);  chk("glitch_b0_pending", 32'(rst_b), 32'h0);
    step(1);   chk("glitch_b0", 32'(rst_b), 32'h1);
    step(16);  chk("glitch_b1", 32'(rst_b), 32'h3);

    // POR drop with bit1 released and bit2 pending.
    step(3);
    por_b = 1'b0;
    step(2);   chk("mid_fall_sync", 32'(rst_b), 32'h3);
    step(1);   chk("mid_fall_rst_b", 32'(rst_b), 32'h0);
    por_b = 1'b1;
    step(66);  chk("mid_restart_pending", 32'(rst_b), 32'h0);
    step(1);   chk("mid_restart_b0", 32'(rst_b), 32'h1);
    step(48);  chk("mid_restart_b3", 32'(rst_b), 32'hF);
    step(1);   chk("mid_restart_done", 32'(done), 32'h1);

    // POR low and software request seen in the same cycle: HOLD wins, so the
    // restart is a plain debounce (bit0 at edge 68), not a 32-cycle SWHOLD.
    por_b = 1'b0;
    step(1);
    por_b = 1'b1;
    step(1);
    sw_req = 1'b1;
    step(1);
    sw_req = 1'b0;
    chk("both_rst_b", 32'(rst_b), 32'h0);
    step(64);  chk("both_b0_pending", 32'(rst_b), 32'h0);
    step(1);   chk("both_b0", 32'(rst_b), 32'h1);
`ifdef RSTSEQ_EVENT_CNT_EN
    chk("evt_por_count", 32'(por_evt), 32'd4);
    chk("evt_sw_count", 32'(sw_evt), 32'd1);
`endif

    // Asynchronous reset mid-RELEASE with POR high.
    step(7);   chk("pre_reset_b0", 32'(rst_b), 32'h1);
    reset = 1'b1;
    #1;
    chk("async_rst_b", 32'(rst_b), 32'h0);
    chk("async_done", 32'(done), 32'h0);
    chk("async_busy", 32'(busy), 32'h1);
    step(1);
    reset = 1'b0;
`ifdef RSTSEQ_EVENT_CNT_EN
    chk("evt_por_cleared", 32'(por_evt), 32'd0);
    chk("evt_sw_cleared", 32'(sw_evt), 32'd0);
`endif
    step(66);  chk("post_reset_pending", 32'(rst_b), 32'h0);
    step(1);   chk("post_reset_b0", 32'(rst_b), 32'h1);

`ifdef RSTSEQ_EVENT_CNT_EN
    // 300 POR drops, each taken from DEBOUNCE; the counter saturates.
    for (int i = 0; i < 300; i++) begin
      por_b = 1'b0;
      step(3);
      por_b = 1'b1;
      step(3);
    end
    chk("evt_por_saturate", 32'(por_evt), 32'd255);
    chk("evt_sw_unchanged", 32'(sw_evt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rd53_reset_sequencer.md
Name: rd53_reset_sequencer

Overview:
Digital controller that consumes the active-low POR output of the power-on-reset macro and produces staged, clock-synchronous, active-low resets for the chip's logic domains. The release order is CDR/clock, then command decoder, then core, then data output.
- Filters the asynchronous POR input and holds all domains in reset until it has been stable high.
- Releases the domains one at a time, with a programmable gap between stages.
- Accepts a software/global-pulse reset request that re-runs the same sequence.
- Sits between the POR macro and all digital reset trees.

Parameters:
NUM_DOMAINS, 4, number of sequenced reset outputs; bit 0 is released first.
DEBOUNCE_CYC, 64, consecutive CLK cycles the synchronized POR must read high before sequencing starts; range 1..65535.
STAGE_GAP_CYC, 16, CLK cycles between successive domain releases; range 1..65535.
SW_HOLD_CYC, 32, minimum CLK cycles all domains stay asserted after a software request; range 1..65535.
SYNC_STAGES, 2, flip-flop depth of the POR input synchronizer; range 2..4.

Ports:
CLK  input  1  free-running system clock.
RESET  input  1  asynchronous, active-high reset; forces the FSM to HOLD.
POR_B  input  1  asynchronous active-low POR from the POR macro; synchronized internally.
SW_RST_REQ  input  1  single-cycle synchronous pulse requesting a full reset sequence.
RST_B_OUT  output  NUM_DOMAINS  active-low domain resets, all registered.
SEQ_DONE  output  1  high when every domain is released (FSM in RUN).
SEQ_BUSY  output  1  high whenever the FSM is not in RUN.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high (RESET).
- While RESET is high: RST_B_OUT = all 0, SEQ_DONE = 0, SEQ_BUSY = 1, FSM = HOLD, all counters = 0.
- POR synchronizer: POR_B passes through SYNC_STAGES flops to produce por_s. While RESET is high, the synchronizer flops reset to 0 (reset asserted).
- FSM states: HOLD, DEBOUNCE, RELEASE, RUN, SWHOLD.
- HOLD:
  - RST_B_OUT = 0.
  - Go to DEBOUNCE the first cycle por_s = 1.
  - Clear the debounce counter.
- DEBOUNCE:
  - The counter increments on every cycle por_s = 1.
  - por_s = 0 returns the FSM to HOLD; the counter clears, so there is no partial credit.
  - Go to RELEASE when the counter reaches DEBOUNCE_CYC-1 with por_s = 1.
  - Minimum latency from por_s rising to first release: DEBOUNCE_CYC + 1 cycles.
- RELEASE:
  - A stage index k starts at 0. On entry, bit 0 of RST_B_OUT rises on the next clock edge.
  - Bit k+1 rises STAGE_GAP_CYC cycles after bit k.
  - Once a bit is released it stays high; no bit is re-asserted individually.
  - After the last bit rises, go to RUN on the following cycle.
- RUN: RST_B_OUT = all 1, SEQ_DONE = 1, SEQ_BUSY = 0.
- Re-entry from any state except HOLD:
  - por_s = 0 → HOLD. All RST_B_OUT bits fall on the next edge; the in-progress sequence is abandoned.
  - SW_RST_REQ = 1 → SWHOLD. All RST_B_OUT bits fall on the next edge.
- SWHOLD:
  - Holds all domains in reset for SW_HOLD_CYC cycles, then goes to DEBOUNCE with the counter cleared.
  - A further SW_RST_REQ during SWHOLD restarts the hold counter.
  - por_s = 0 during SWHOLD → HOLD.
- Priority in the same cycle: RESET > por_s low > SW_RST_REQ > counter expiry.
- SW_RST_REQ in HOLD is ignored.
- Counters: widths are the clog2 of the largest parameter, saturate-free, compared for equality.
- Outputs are glitch-free: each is a direct flop output, with no combinational decode on RST_B_OUT.

Optional Feature:
Macro RSTSEQ_EVENT_CNT_EN.
- Defined:
  - Adds output POR_EVT_CNT, 8 bits.
  - The counter increments once per transition into HOLD from DEBOUNCE, RELEASE, RUN or SWHOLD that is caused by por_s low.
  - Saturates at 255. Cleared only by RESET.
  - Adds output SW_EVT_CNT, 8 bits, which behaves the same way for accepted SW_RST_REQ pulses.
- Undefined: neither port nor its logic exists, and behaviour is otherwise identical.

Decomposition:
- Package rd53_reset_pkg holds:
  - the enum typedef rstseq_state_t {HOLD, DEBOUNCE, RELEASE, RUN, SWHOLD};
  - localparam default cycle counts;
  - the function cnt_width(max) returning clog2.
- One sub-module, rd53_sync_rst_n: a parameterized SYNC_STAGES synchronizer with async reset, reusable by other domains.
- The FSM and counters remain in the top module.

Test Plan:
- POR_B 0→1 at t0 with defaults → RST_B_OUT bit0 rises at ≈t0 + (2+64+1) cycles; bits 1, 2, 3 follow at +16, +32, +48; SEQ_DONE rises one cycle after bit3.
- POR_B low-glitch of 1 cycle at debounce count 40 → FSM returns to HOLD and the counter restarts; the first release occurs 64+ cycles after the glitch ends.
- POR_B falls while bit1 is released and bit2 is pending → all RST_B_OUT go to 0 within SYNC_STAGES+1 cycles; a full sequence restarts after POR_B returns high.
- SW_RST_REQ pulse in RUN → all outputs 0 next edge; held for 32 cycles, then 64-cycle debounce, then the staged release; SEQ_BUSY stays high throughout.
- SW_RST_REQ and POR low in the same cycle → HOLD wins; with RSTSEQ_EVENT_CNT_EN defined, POR_EVT_CNT increments by 1 and SW_EVT_CNT is unchanged.
- RESET asserted mid-RELEASE with POR_B high → immediate outputs 0 / DONE 0 / BUSY 1; after deassert, the full sequence runs from HOLD. With RSTSEQ_EVENT_CNT_EN defined, drive 300 POR events → POR_EVT_CNT = 255.
